// File: rtl/pipeline_pkg.sv
// Shared constants and types for the ID-stage early-branch hazard logic.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic {IDLE, HOLD} state_t;

  // A loaded value still in MEM cannot be forwarded; fall through to WB.
  function automatic logic [1:0] fwd_sel(logic mem_match, logic mem_load, logic wb_match);
    if (mem_match && !mem_load) return FWD_MEM;
    if (wb_match) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand RAW dependence check against EX, MEM and WB, with stall requirement.
module hazard_match import pipeline_pkg::*; #(
  parameter int unsigned REG_W = pipeline_pkg::REG_W
) (
  input  logic             used,
  input  logic [REG_W-1:0] rs,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  output logic             mem_match,
  output logic             wb_match,
  output logic [1:0]       req
);

  logic ex_match;

  always_comb begin
    ex_match  = used && ex_regwrite  && (ex_rd  != '0) && (ex_rd  == rs);
    mem_match = used && mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
    wb_match  = used && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);
    req = 2'd0;
    if (ex_match) begin
      req = ex_memread ? 2'd2 : 2'd1;
    end else if (mem_match && mem_memread) begin
      req = 2'd1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls, comparator forwarding, redirect and counters.
module branch_hazard_ctrl import pipeline_pkg::*; #(
  parameter int unsigned REG_W = pipeline_pkg::REG_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_Branch,
  input  logic             ID_JumpReg,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [REG_W-1:0] MEM_Rd,
  input  logic             WB_RegWrite,
  input  logic [REG_W-1:0] WB_Rd,
  input  logic             Freeze,
  input  logic             Branch_Taken,
  output logic             Stall,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             PCSrc_Branch,
  output logic             Flush_IFID,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] TakenCount
);

  state_t           state_q, state_d;
  logic             use_rs, use_rt;
  logic             mem_match_a, wb_match_a, mem_match_b, wb_match_b;
  logic [1:0]       req_a, req_b, req_max;
  logic [1:0]       fwd_a, fwd_b, fwd_a_q, fwd_b_q;
  logic             stall_raw, stall_q, redirect;
  logic [CNT_W-1:0] stall_cnt_q, taken_cnt_q;

  assign use_rs = ID_Branch | ID_JumpReg;
  assign use_rt = ID_Branch;

  hazard_match #(.REG_W(REG_W)) u_match_a (
    .used         (use_rs),
    .rs           (ID_Rs),
    .ex_regwrite  (EX_RegWrite),
    .ex_memread   (EX_MemRead),
    .ex_rd        (EX_Rd),
    .mem_regwrite (MEM_RegWrite),
    .mem_memread  (MEM_MemRead),
    .mem_rd       (MEM_Rd),
    .wb_regwrite  (WB_RegWrite),
    .wb_rd        (WB_Rd),
    .mem_match    (mem_match_a),
    .wb_match     (wb_match_a),
    .req          (req_a)
  );

  hazard_match #(.REG_W(REG_W)) u_match_b (
    .used         (use_rt),
    .rs           (ID_Rt),
    .ex_regwrite  (EX_RegWrite),
    .ex_memread   (EX_MemRead),
    .ex_rd        (EX_Rd),
    .mem_regwrite (MEM_RegWrite),
    .mem_memread  (MEM_MemRead),
    .mem_rd       (MEM_Rd),
    .wb_regwrite  (WB_RegWrite),
    .wb_rd        (WB_Rd),
    .mem_match    (mem_match_b),
    .wb_match     (wb_match_b),
    .req          (req_b)
  );

  always_comb begin
    fwd_a     = fwd_sel(mem_match_a, MEM_MemRead, wb_match_a);
    fwd_b     = fwd_sel(mem_match_b, MEM_MemRead, wb_match_b);
    req_max   = (req_a > req_b) ? req_a : req_b;
    // HOLD stalls blindly; the load has not reached WB yet.
    stall_raw = (state_q == HOLD) || (req_max != 2'd0);
    state_d   = ((state_q == IDLE) && (req_max == 2'd2)) ? HOLD : IDLE;
    redirect  = use_rs && !stall_raw && !Freeze && !reset
                && (ID_JumpReg || (ID_Branch && Branch_Taken));

    Stall    = stall_raw;
    ForwardA = fwd_a;
    ForwardB = fwd_b;
    if (reset) begin
      Stall    = 1'b0;
      ForwardA = FWD_REG;
      ForwardB = FWD_REG;
    end else if (Freeze) begin
      Stall    = stall_q;
      ForwardA = fwd_a_q;
      ForwardB = fwd_b_q;
    end
    PCSrc_Branch = redirect;
    Flush_IFID   = redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else if (!Freeze) begin
      state_q <= state_d;
      stall_q <= stall_raw;
      fwd_a_q <= fwd_a;
      fwd_b_q <= fwd_b;
      if (stall_raw && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign TakenCount = taken_cnt_q;

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Sequences the ID-stage early-branch comparator. For every branch or jr in ID, it detects read-after-write dependences on instructions still in EX, MEM or WB and stalls IF/ID until the operands can be forwarded. It then drives the comparator's operand-forwarding selects, issues the taken-branch redirect and IF/ID flush, and keeps saturating stall and taken-branch counters. It sits beside the ID-stage decoder and drives the PC mux, the IF/ID register enable and flush, and the ID/EX bubble insert.

## Interface
- REG_W, 5, register-address width
- CNT_W, 32, width of the performance counters
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- ID_Branch  in  1  ID holds a conditional branch (uses Rs and Rt)
- ID_JumpReg  in  1  ID holds jr/jalr (uses Rs only)
- ID_Rs, ID_Rt  in  REG_W  source registers in ID
- EX_RegWrite, EX_MemRead  in  1  EX-stage write enable, load flag
- EX_Rd  in  REG_W  EX destination register
- MEM_RegWrite, MEM_MemRead  in  1  MEM-stage write enable, load flag
- MEM_Rd  in  REG_W  MEM destination register
- WB_RegWrite  in  1  WB write enable
- WB_Rd  in  REG_W  WB destination register
- Freeze  in  1  global pipeline hold (memory busy); FSM and counters hold
- Branch_Taken  in  1  comparator result, bit 0
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- ForwardA, ForwardB  out  2  comparator operand select: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB write data
- PCSrc_Branch  out  1  select the branch or jr target this cycle
- Flush_IFID  out  1  squash the instruction in IF/ID
- StallCount, TakenCount  out  CNT_W  saturating counters

## Operation
- A match means the stage's RegWrite is set, its Rd is nonzero and Rd equals a used source. Rt is used only when ID_Branch is set.
- Stall requirement per used operand:
  - EX match with EX_MemRead set: 2 cycles.
  - EX match otherwise: 1 cycle.
  - MEM match with MEM_MemRead set: 1 cycle.
  - Otherwise: 0.
- The block's requirement is the maximum over the used operands. The EX match takes precedence over MEM and WB for the same operand.
- Forward select per operand, computed every cycle: MEM match and not MEM_MemRead gives 1, else WB match gives 2, else 0. When neither ID_Branch nor ID_JumpReg is set, both selects are 0.
- FSM states:
  - IDLE, in a cycle where Freeze is low:
    - Requirement 0: Stall = 0.
    - Requirement 1: Stall = 1, remain in IDLE. The requirement is re-evaluated next cycle.
    - Requirement 2: Stall = 1, go to HOLD.
  - HOLD: Stall = 1 unconditionally, with no re-evaluation. Next state is IDLE.
- Resolve happens in any cycle where ID_Branch or ID_JumpReg is set, Stall is 0 and Freeze is low:
  - PCSrc_Branch = ID_JumpReg | (ID_Branch & Branch_Taken).
  - Flush_IFID = PCSrc_Branch.
- Counters:
  - StallCount increments once per cycle in which Stall = 1 and Freeze is low.
  - TakenCount increments once per cycle in which PCSrc_Branch = 1.
  - Both counters saturate at all-ones.
- Freeze: state, counters, Stall and Forward hold their values. PCSrc_Branch and Flush_IFID are forced to 0.

## Timing
- Stall, the Forward selects, PCSrc_Branch and Flush_IFID are combinational from the current inputs and state, valid in the same cycle. The state and counters update on the clk edge.
- Load-to-branch costs 2 stall cycles, then resolves forwarding from WB (select 2). ALU-to-branch in EX costs 1 stall, then resolves forwarding from MEM (select 1).
- Reset, sampled at a clk edge: state = IDLE and both counters = 0. During reset, Stall, PCSrc_Branch and Flush_IFID = 0 and both Forward selects = 0. Reset takes priority over Freeze.
- Reset asserted while in HOLD returns to IDLE on the next edge with no further stall.
- A branch immediately following a resolved branch is evaluated fresh in IDLE. Counter saturation must not wrap.

## Structure
- Shared package pipeline_pkg:
  - Forward-select constants FWD_REG = 0, FWD_MEM = 1, FWD_WB = 2.
  - FSM state encoding IDLE and HOLD.
  - REG_W.
- One natural sub-module, hazard_match. It is instantiated once per operand and returns the match flags and the stall requirement.
- The FSM and counters live in the top module.

## Test plan
- EX_MemRead = 1, EX_Rd = 8; branch in ID with Rs = 8 -> Stall = 1 for exactly 2 cycles (IDLE, HOLD). Next cycle ForwardA = 2 and Stall = 0. StallCount = 2.
- EX non-load, EX_Rd = 9; branch with Rt = 9 -> 1 stall cycle, then ForwardB = 1. With Branch_Taken = 1: PCSrc_Branch = 1, Flush_IFID = 1, TakenCount = 1.
- EX_Rd = 0 with RegWrite set; branch with Rs = 0 -> no stall and ForwardA = 0. jr with Rt matching EX_Rd -> no stall, because Rt is unused.
- MEM match (non-load, Rd = 5) and WB match (Rd = 5); branch with Rs = 5 -> ForwardA = 1, so MEM has priority over WB.
- Freeze = 1 held for 3 cycles during HOLD -> state, Stall and counters unchanged. PCSrc_Branch = 0. Once Freeze drops, the sequence completes as normal.
- Reset in HOLD -> next cycle Stall = 0 and counters = 0. StallCount preset near all-ones and stalled twice -> stays at all-ones.
